// File: rtl/seq_checker.sv
// seq_checker: secret-string recognizer with consecutive-failure lockout.
// Define CHECKER_TRACE_EN to expose the mismatch pulse and fail_cnt outputs.
module seq_checker #(
   parameter int               LEN         = 49,
   parameter logic [7*LEN-1:0] SECRET      = '0,
   parameter int               MAX_FAILS   = 3,
   parameter int               LOCK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [6:0] next_byte,
   output logic       ready,
   output logic [7:0] state,
   output logic       win,
   output logic       locked
`ifdef CHECKER_TRACE_EN
   ,
   output logic       mismatch,
   output logic [3:0] fail_cnt
`endif
);
   typedef enum logic [1:0] {MATCH, LOCK, WIN} fsm_t;
   fsm_t fsm, fsm_n;
   logic [7:0] cnt_n;
   logic [3:0] fails, fails_n;
   logic [15:0] timer, timer_n;
   logic [6:0] want;
   logic acc, hit;
   assign want   = SECRET[7*int'(state) +: 7];
   assign acc    = en && fsm == MATCH;
   assign hit    = next_byte == want;
   assign ready  = fsm == MATCH;
   assign locked = fsm == LOCK;
   assign win    = fsm == WIN;
   always_comb begin
      fsm_n   = fsm;
      cnt_n   = state;
      fails_n = fails;
      timer_n = timer;
      if (acc && hit) begin
         cnt_n   = state + 8'd1;
         fails_n = '0;
         fsm_n   = cnt_n == 8'(LEN) ? WIN : MATCH;
      end else if (acc) begin
         cnt_n   = '0;
         fails_n = fails + 4'd1;
         if (fails_n == 4'(MAX_FAILS)) begin
            fsm_n   = LOCK;
            timer_n = 16'(LOCK_CYCLES - 1);
            fails_n = '0;
         end
      end else if (fsm == LOCK) begin
         // timer counts LOCK_CYCLES-1 down to 0, so ready stays low for exactly LOCK_CYCLES cycles
         timer_n = timer == '0 ? timer : timer - 16'd1;
         fsm_n   = timer == '0 ? MATCH : LOCK;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm   <= MATCH;
         state <= '0;
         fails <= '0;
         timer <= '0;
      end else begin
         fsm   <= fsm_n;
         state <= cnt_n;
         fails <= fails_n;
         timer <= timer_n;
      end
   end
`ifdef CHECKER_TRACE_EN
   assign fail_cnt = fails;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mismatch <= 1'b0;
      else     mismatch <= acc && !hit;
   end
`endif
endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: directed and randomized checks of seq_checker against a behavioural model.
module tb_seq_checker;
   logic clk = 0, rst = 1, en = 0;
   logic [6:0] next_byte = '0;
   logic ready, win, locked;
   logic [7:0] state;
`ifdef CHECKER_TRACE_EN
   logic mismatch;
   logic [3:0] fail_cnt;
`endif
   int n_chk = 0, n_err = 0;
   int m_prog, m_fails, m_lock;
   bit m_win, m_mis;
   logic [6:0] sec [3] = '{7'h70, 7'h62, 7'h63};

   seq_checker #(.LEN(3), .SECRET({7'h63, 7'h62, 7'h70}), .MAX_FAILS(3), .LOCK_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .en(en), .next_byte(next_byte),
      .ready(ready), .state(state), .win(win), .locked(locked)
`ifdef CHECKER_TRACE_EN
      , .mismatch(mismatch), .fail_cnt(fail_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check("state", 32'(state), 32'(m_prog));
      check("ready", 32'(ready), 32'(!m_win && m_lock == 0));
      check("locked", 32'(locked), 32'(m_lock > 0));
      check("win", 32'(win), 32'(m_win));
`ifdef CHECKER_TRACE_EN
      check("mismatch", 32'(mismatch), 32'(m_mis));
      check("fail_cnt", 32'(fail_cnt), 32'(m_fails));
`endif
   endtask

   task automatic model_clear();
      m_prog = 0; m_fails = 0; m_lock = 0; m_win = 0; m_mis = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      #2;
      model_clear();
      check_all();
      rst = 0;
   endtask

   task automatic tick(input logic e, input logic [6:0] b);
      en = e;
      next_byte = b;
      @(posedge clk);
      m_mis = 0;
      if (m_win) ;
      else if (m_lock > 0) m_lock--;
      else if (e) begin
         if (b == sec[m_prog]) begin
            m_prog++;
            m_fails = 0;
            m_win = m_prog == 3;
         end else begin
            m_prog = 0;
            m_fails++;
            m_mis = 1;
            if (m_fails == 3) begin
               m_lock = 16;
               m_fails = 0;
            end
         end
      end
      #1 check_all();
   endtask

   initial begin
      int low;
      logic [6:0] b;
      model_clear();
      #2 check_all();
      rst = 0;
      // full match, then extra bytes ignored in WIN
      tick(1, "p"); tick(1, "b"); tick(1, "c");
      tick(1, "x"); tick(1, "p");
      // mismatch recovery
      do_reset();
      tick(1, "p"); tick(1, "x"); tick(1, "p"); tick(1, "b"); tick(1, "c");
      // lockout: count ready-low cycles while offering a correct byte
      do_reset();
      tick(1, "x"); tick(1, "y"); tick(1, "z");
      low = 1;
      for (int i = 0; i < 40 && !ready; i++) begin
         tick(1, "p");
         if (!ready) low++;
      end
      check("lock_len", 32'(low), 32'd16);
      tick(1, "p");
      // async reset mid-lockout, between clock edges
      tick(1, "x"); tick(1, "y"); tick(1, "x");
      for (int i = 0; i < 8; i++) tick(1, "p");
      #2 rst = 1;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_locked", 32'(locked), 32'd0);
      rst = 0;
      model_clear();
      tick(1, "p");
      // enable gating
      for (int i = 0; i < 5; i++) tick(0, "b");
      tick(1, "b");
      // async reset mid-WIN
      tick(1, "c");
      do_reset();
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (m_win || $urandom_range(0, 80) == 0) do_reset();
         b = $urandom_range(0, 3) == 0 ? 7'($urandom) : sec[m_prog];
         tick($urandom_range(0, 4) != 0, b);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
